// File: rtl/int8_vec_packer_pkg.sv
// ---------------------------------------------------------------------------
// int8_pkg
// The int8 vector layout and quantiser constants, kept in one place. The
// packer and the MAC array both import this package, so they always agree
// on the layout.
//   IN_W      signed activation width
//   N_ELEM    elements per packed vector
//   VEC_W     packed vector width: byte 0 is the scale, bytes 1..N_ELEM are the elements
//   SCALE_MAX largest power-of-two shift a 16-bit input can need
//   Q_MAX/Q_MIN symmetric int8 clamp range (-128 is never produced)
// ---------------------------------------------------------------------------
package int8_pkg;

    localparam int IN_W      = 16;
    localparam int N_ELEM    = 32;
    localparam int VEC_W     = (N_ELEM + 1) * 8;
    localparam int MAG_W     = IN_W + 1;   // |-32768| needs 17 bits
    localparam int CNT_W     = $clog2(N_ELEM);
    localparam int SCALE_MAX = 9;
    localparam int SCALE_W   = 4;
    localparam int Q_MAX     = 127;
    localparam int Q_MIN     = -127;

    typedef enum logic [1:0] {
        FILL,
        SCALE,
        EMIT
    } state_t;

    // Returns the smallest shift s in 0..SCALE_MAX with (mag >> s) <= Q_MAX.
    // The loop runs downward, so the last shift that qualifies is the smallest one.
    function automatic logic [SCALE_W-1:0] pick_scale(input logic [MAG_W-1:0] mag);
        pick_scale = SCALE_W'(SCALE_MAX);
        for (int s = SCALE_MAX; s >= 0; s--) begin
            if ((mag >> s) <= MAG_W'(Q_MAX))
                pick_scale = SCALE_W'(s);
        end
    endfunction

endpackage

// File: rtl/int8_vec_packer_if.sv
// ---------------------------------------------------------------------------
// int8_vec_packer_if
// The handshake signals of the packer, grouped in one bundle.
//   in_valid/in_ready/in_data/in_last : activation stream into the packer
//   out_valid/out_ready/out_vec/out_sat : packed vector stream to the MAC array
// Modports:
//   master : the packer itself. It drives in_ready and the whole output stream.
//   slave  : the environment, meaning the upstream producer and the downstream consumer.
// ---------------------------------------------------------------------------
interface int8_vec_packer_if;
    import int8_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [VEC_W-1:0]       out_vec;
    logic                   out_sat;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_sat
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_sat
    );

endinterface

// File: rtl/int8_quant_lane.sv
// ---------------------------------------------------------------------------
// int8_quant_lane
// Combinational quantiser for one element. It shifts right arithmetically
// by the block scale, optionally rounds, and clamps to [Q_MIN, Q_MAX].
//   x     signed IN_W-bit element
//   s     block scale (shift amount)
//   q     int8 result, two's complement
//   sat   high when the clamp changed the value
// Build option: with INT8_PACK_ROUND_EN defined, the lane adds half an LSB
// of the result before the shift (round to nearest). Without it, the shift
// truncates toward minus infinity.
// ---------------------------------------------------------------------------
module int8_quant_lane
    import int8_pkg::*;
(
    input  logic signed [IN_W-1:0]    x,
    input  logic        [SCALE_W-1:0] s,
    output logic        [7:0]         q,
    output logic                      sat
);

    // 18 bits hold the largest input plus the largest rounding bias.
    logic signed [IN_W+1:0] x_ext;
    logic signed [IN_W+1:0] shifted;

    assign x_ext = {{2{x[IN_W-1]}}, x};

`ifdef INT8_PACK_ROUND_EN
    logic signed [IN_W+1:0] bias;
    assign bias    = (s == '0) ? '0 : (18'sd1 <<< (s - 1'b1));
    assign shifted = (x_ext + bias) >>> s;
`else
    assign shifted = x_ext >>> s;
`endif

    // NOTE: give every always_comb output a default first, so that no path leaves it unassigned and a latch is inferred.
    always_comb begin
        q   = shifted[7:0];
        sat = 1'b0;
        if (shifted > 18'(Q_MAX)) begin
            q   = 8'(Q_MAX);
            sat = 1'b1;
        end else if (shifted < 18'(Q_MIN)) begin
            q   = 8'(Q_MIN);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/int8_vec_packer.sv
// ---------------------------------------------------------------------------
// int8_vec_packer
// Collects signed 16-bit activations into blocks of N_ELEM. It finds one
// power-of-two scale per block, quantises every element to int8, and emits a
// packed vector: byte 0 holds the scale and byte k+1 holds element k.
//   clk    rising-edge clock
//   rst_n  synchronous, active-low reset
//   bus    int8_vec_packer_if.master (input stream, in_last ends a short block;
//          output stream carries out_vec and the per-vector out_sat flag)
// Build option: INT8_PACK_ROUND_EN switches the lanes to round-to-nearest.
// The ports and the latency stay the same in both builds.
// Flow: FILL accepts elements. SCALE registers the quantised vector in one
// cycle. EMIT holds the vector until out_ready. A short block is zero-padded,
// because the buffer is cleared after every vector it sends.
// ---------------------------------------------------------------------------
module int8_vec_packer
    import int8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    int8_vec_packer_if.master    bus
);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [MAG_W-1:0]       max_abs;
    logic signed [IN_W-1:0] elem_buf [N_ELEM];

    logic [MAG_W-1:0]       in_ext;
    logic [MAG_W-1:0]       in_mag;
    logic [SCALE_W-1:0]     scale;
    logic [7:0]             q [N_ELEM];
    logic [N_ELEM-1:0]      lane_sat;
    logic [VEC_W-1:0]       vec_next;

    // Take the magnitude at 17 bits, so that -32768 gives +32768 instead of wrapping.
    assign in_ext = {bus.in_data[IN_W-1], bus.in_data};
    assign in_mag = bus.in_data[IN_W-1] ? (~in_ext + 1'b1) : in_ext;

    assign scale = pick_scale(max_abs);

    for (genvar k = 0; k < N_ELEM; k++) begin : g_lane
        int8_quant_lane u_lane (
            .x   (elem_buf[k]),
            .s   (scale),
            .q   (q[k]),
            .sat (lane_sat[k])
        );
    end

    always_comb begin
        vec_next      = '0;
        vec_next[7:0] = {{(8-SCALE_W){1'b0}}, scale};
        for (int k = 0; k < N_ELEM; k++)
            vec_next[(k+1)*8 +: 8] = q[k];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FILL;
            cnt           <= '0;
            max_abs       <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_vec   <= '0;
            bus.out_sat   <= 1'b0;
            // NOTE: the buffer is cleared on reset because it supplies the zero padding of short blocks; it is a register bank, not a RAM.
            for (int k = 0; k < N_ELEM; k++)
                elem_buf[k] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        elem_buf[cnt] <= bus.in_data;
                        if (in_mag > max_abs)
                            max_abs <= in_mag;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(N_ELEM - 1) || bus.in_last) begin
                            state        <= SCALE;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                SCALE: begin
                    bus.out_vec   <= vec_next;
                    bus.out_sat   <= |lane_sat;
                    bus.out_valid <= 1'b1;
                    state         <= EMIT;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        cnt           <= '0;
                        max_abs       <= '0;
                        for (int k = 0; k < N_ELEM; k++)
                            elem_buf[k] <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_int8_vec_packer.sv
// ---------------------------------------------------------------------------
// tb_int8_vec_packer
// Directed bench for int8_vec_packer. Each block's stimulus and expected
// int8 values are written out by hand. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Pass +define+INT8_PACK_ROUND_EN
// for the rounding build.
// ---------------------------------------------------------------------------
module tb_int8_vec_packer;
    import int8_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic signed [IN_W-1:0] stim  [N_ELEM];
    int                     exp_q [N_ELEM];

    int8_vec_packer_if bus ();

    int8_vec_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tables();
        for (int k = 0; k < N_ELEM; k++) begin
            stim[k]  = '0;
            exp_q[k] = 0;
        end
    endtask

    function automatic logic [VEC_W-1:0] pack_exp(input int s);
        pack_exp      = '0;
        pack_exp[7:0] = 8'(s);
        for (int k = 0; k < N_ELEM; k++)
            pack_exp[(k+1)*8 +: 8] = 8'(exp_q[k]);
    endfunction

    // Sends stim[0..n-1] and checks latency and the emitted vector. It then
    // holds out_ready low for 'hold' cycles while junk input is offered, and
    // finally completes the handshake.
    task automatic run_block(input string tag, input int n, input bit use_last,
                             input int exp_s, input bit exp_sat, input int hold);
        logic [VEC_W-1:0] exp_vec;
        exp_vec = pack_exp(exp_s);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0)
                check({tag, "_rdy_fill"}, VEC_W'(bus.in_ready), VEC_W'(1'b1));
            bus.in_valid = 1'b1;
            bus.in_data  = stim[i];
            bus.in_last  = use_last && (i == n - 1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({tag, "_valid_n1"}, VEC_W'(bus.out_valid), VEC_W'(1'b0));
        check({tag, "_rdy_scale"}, VEC_W'(bus.in_ready), VEC_W'(1'b0));
        @(negedge clk);
        check({tag, "_valid_n2"}, VEC_W'(bus.out_valid), VEC_W'(1'b1));
        check({tag, "_scale"}, VEC_W'(bus.out_vec[7:0]), VEC_W'(exp_s));
        check({tag, "_vec"}, bus.out_vec, exp_vec);
        check({tag, "_sat"}, VEC_W'(bus.out_sat), VEC_W'(exp_sat));
        check({tag, "_rdy_emit"}, VEC_W'(bus.in_ready), VEC_W'(1'b0));
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'sh1234;
            @(negedge clk);
            check({tag, "_hold_vec"}, bus.out_vec, exp_vec);
            check({tag, "_hold_sat"}, VEC_W'(bus.out_sat), VEC_W'(exp_sat));
            check({tag, "_hold_valid"}, VEC_W'(bus.out_valid), VEC_W'(1'b1));
            check({tag, "_hold_rdy"}, VEC_W'(bus.in_ready), VEC_W'(1'b0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_done_valid"}, VEC_W'(bus.out_valid), VEC_W'(1'b0));
        check({tag, "_done_rdy"}, VEC_W'(bus.in_ready), VEC_W'(1'b1));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", VEC_W'(bus.in_ready), VEC_W'(1'b1));
        check("rst_out_valid", VEC_W'(bus.out_valid), VEC_W'(1'b0));
        check("rst_out_vec", bus.out_vec, '0);
        check("rst_out_sat", VEC_W'(bus.out_sat), VEC_W'(1'b0));

        // Ramp 0..31: s=0, element k equals k.
        clear_tables();
        for (int k = 0; k < N_ELEM; k++) begin
            stim[k]  = 16'(k);
            exp_q[k] = k;
        end
        run_block("ramp", N_ELEM, 1'b0, 0, 1'b0, 0);

        // Short block: in_last on the 5th element; the remaining slots pad with zero.
        clear_tables();
        for (int k = 0; k < 5; k++) begin
            stim[k]  = 16'((k + 1) * 10);
            exp_q[k] = (k + 1) * 10;
        end
        run_block("short", 5, 1'b1, 0, 1'b0, 0);

        // All 1000: 1000>>3 = 125 in both builds (1004>>3 = 125 when rounding).
        clear_tables();
        for (int k = 0; k < N_ELEM; k++) begin
            stim[k]  = 16'sd1000;
            exp_q[k] = 125;
        end
        run_block("k1000", N_ELEM, 1'b0, 3, 1'b0, 0);

        // -32768 alone: s=9, -64 (rounding: -32512>>>9 = -64). Also in_last on the 32nd element.
        clear_tables();
        stim[0]  = -16'sd32768;
        exp_q[0] = -64;
        run_block("minval", N_ELEM, 1'b1, 9, 1'b0, 0);

        // +/-255: s=1. Truncating gives -128 -> -127 (sat) and 127.
        // Rounding gives -127 and 128 -> 127 (sat). The vector is the same in both builds.
        clear_tables();
        stim[0]  = -16'sd255;
        stim[1]  = 16'sd255;
        exp_q[0] = -127;
        exp_q[1] = 127;
        run_block("clamp", N_ELEM, 1'b0, 1, 1'b1, 0);

        // Backpressure: alternating +/-100, out_ready held low for 5 cycles
        // while junk input is offered.
        clear_tables();
        for (int k = 0; k < N_ELEM; k++) begin
            stim[k]  = (k % 2 == 0) ? 16'sd100 : -16'sd100;
            exp_q[k] = (k % 2 == 0) ? 100 : -100;
        end
        run_block("bp", N_ELEM, 1'b0, 0, 1'b0, 5);

        // Reset during a partial fill discards the partial block.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(7 + i);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("partial_no_valid", VEC_W'(bus.out_valid), VEC_W'(1'b0));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_in_ready", VEC_W'(bus.in_ready), VEC_W'(1'b1));
        check("mrst_out_valid", VEC_W'(bus.out_valid), VEC_W'(1'b0));
        check("mrst_out_vec", bus.out_vec, '0);
        check("mrst_out_sat", VEC_W'(bus.out_sat), VEC_W'(1'b0));

        // After the reset, a one-element block must not contain any of 7, 8, 9.
        clear_tables();
        stim[0]  = 16'sd5;
        exp_q[0] = 5;
        run_block("post_rst", 1, 1'b1, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
